// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage between ID and MEM.
// Decodes aluop/funct to an operation and computes it. ADD/SUB/AND/OR/SLT/NOP
// and the degenerate cases (illegal code, divide by zero) complete in one cycle.
// MUL (shift-add) and DIV (restoring) take one bit per cycle, WIDTH iterations.
// Optional feature macro: ALU_FLAGS_EN adds the zero and ovf outputs.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only when idle)
//   aluop[2:0], funct[5:0], a, b   opcode and operands, sampled on acceptance
//   out_valid / out_ready result handshake (result held until out_ready)
//   result, rem          low/high product, quotient/remainder, or single-cycle result
//   div_zero, illegal    status, valid with out_valid
//   zero, ovf            (ALU_FLAGS_EN) result==0, signed ADD/SUB overflow
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_NOP, OP_ILL
  } op_e;

  state_e             state, state_next;
  op_e                dec_op;
  logic [WIDTH-1:0]   b_q, b_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   result_next, rem_next;
  logic               div_zero_next, illegal_next;
  logic [WIDTH-1:0]   add_res, sub_res;
  logic               slt_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
`ifdef ALU_FLAGS_EN
  logic               zero_next, ovf_next, add_ovf, sub_ovf;
`endif

  // Opcode decode
  always_comb begin
    dec_op = OP_ILL;
    case (aluop)
      3'b000: dec_op = OP_ADD;
      3'b001: dec_op = OP_SUB;
      3'b011: dec_op = OP_AND;
      3'b100: dec_op = OP_OR;
      3'b101: dec_op = OP_SLT;
      3'b010: begin
        case (funct)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b011000: dec_op = OP_MUL;
          6'b011010: dec_op = OP_DIV;
          6'b000000: dec_op = OP_NOP;
          default:   dec_op = OP_ILL;
        endcase
      end
      default: dec_op = OP_ILL;
    endcase
  end

  // Single-cycle arithmetic straight from the operand inputs
  always_comb begin
    add_res = a + b;
    sub_res = a - b;
    slt_res = $signed(a) < $signed(b);
`ifdef ALU_FLAGS_EN
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
`endif
  end

  // Iteration steps; result/rem double as the working registers:
  // MUL keeps {rem,result} = {partial high, shifting multiplier},
  // DIV keeps rem = partial remainder, result = dividend shifting into quotient.
  always_comb begin
    mul_sum   = {1'b0, rem} + (result[0] ? {1'b0, b_q} : '0);
    div_shift = {rem, result[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift - {1'b0, b_q};
  end

  // Next-state and datapath next values
  always_comb begin
    state_next    = state;
    b_next        = b_q;
    cnt_next      = cnt;
    result_next   = result;
    rem_next      = rem;
    div_zero_next = div_zero;
    illegal_next  = illegal;
`ifdef ALU_FLAGS_EN
    ovf_next      = ovf;
    zero_next     = zero;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          b_next        = b;
          cnt_next      = '0;
          rem_next      = '0;
          div_zero_next = 1'b0;
          illegal_next  = 1'b0;
          state_next    = S_DONE;
`ifdef ALU_FLAGS_EN
          ovf_next      = 1'b0;
`endif
          case (dec_op)
            OP_ADD: begin
              result_next = add_res;
`ifdef ALU_FLAGS_EN
              ovf_next    = add_ovf;
`endif
            end
            OP_SUB: begin
              result_next = sub_res;
`ifdef ALU_FLAGS_EN
              ovf_next    = sub_ovf;
`endif
            end
            OP_AND: result_next = a & b;
            OP_OR:  result_next = a | b;
            OP_SLT: result_next = WIDTH'(slt_res);
            OP_NOP: result_next = '0;
            OP_MUL: begin
              result_next = a;
              state_next  = S_MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_next   = '1;
                rem_next      = a;
                div_zero_next = 1'b1;
              end else begin
                result_next = a;
                state_next  = S_DIV;
              end
            end
            default: begin
              result_next  = '0;
              illegal_next = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        {rem_next, result_next} = {mul_sum, result[WIDTH-1:1]};
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ITER) state_next = S_DONE;
      end
      S_DIV: begin
        rem_next    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        result_next = {result[WIDTH-2:0], div_ge};
        cnt_next    = cnt + 1'b1;
        if (cnt == LAST_ITER) state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
`ifdef ALU_FLAGS_EN
    if (state_next == S_DONE) zero_next = (result_next == '0);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      b_q       <= '0;
      cnt       <= '0;
      result    <= '0;
      rem       <= '0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      b_q       <= b_next;
      cnt       <= cnt_next;
      result    <= result_next;
      rem       <= rem_next;
      div_zero  <= div_zero_next;
      illegal   <= illegal_next;
`ifdef ALU_FLAGS_EN
      zero      <= zero_next;
      ovf       <= ovf_next;
`endif
    end
  end

endmodule
